// File: rtl/stage_id_fwd_if.sv
// stage_id_fwd_if: IF->ID->EX handshake, regfile read, and bypass bundle for stage_id_fwd.
// master = surrounding pipeline (IF, regfile, downstream stages, EX); slave = the ID stage.
// N_FWD must match the N_FWD of the stage it is connected to.
interface stage_id_fwd_if #(
  parameter int N_FWD = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [31:0]          in_pc;
  logic [4:0]           RF_raddr1;
  logic [4:0]           RF_raddr2;
  logic [31:0]          RF_rdata1;
  logic [31:0]          RF_rdata2;
  logic [N_FWD-1:0]     fwd_valid;
  logic [5*N_FWD-1:0]   fwd_rd;
  logic [32*N_FWD-1:0]  fwd_data;
  logic [N_FWD-1:0]     fwd_pend;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic [31:0]          out_rr1;
  logic [31:0]          out_rr2;
  logic [31:0]          out_imm;
  logic [31:0]          out_tgt;
  logic [4:0]           out_rd;
  logic [19:0]          out_dcr;
  logic                 out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, RF_rdata1, RF_rdata2,
           fwd_valid, fwd_rd, fwd_data, fwd_pend, flush, out_ready,
    input  in_ready, RF_raddr1, RF_raddr2, out_valid, out_pc, out_rr1,
           out_rr2, out_imm, out_tgt, out_rd, out_dcr, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, RF_rdata1, RF_rdata2,
           fwd_valid, fwd_rd, fwd_data, fwd_pend, flush, out_ready,
    output in_ready, RF_raddr1, RF_raddr2, out_valid, out_pc, out_rr1,
           out_rr2, out_imm, out_tgt, out_rd, out_dcr, out_illegal
  );
endinterface

// File: rtl/stage_id_fwd.sv
// stage_id_fwd: RV32 decode + regfile read + N-source bypass, load-use stall, flush, branch/jump targets.
// Latency 1 cycle from accept to out_valid; payload frozen while out_valid & ~out_ready.
// Optional macro ID_MULDIV_EN: full M extension (funct7=1, any funct3); otherwise only MUL is legal.
module stage_id_fwd #(
  parameter int          N_FWD  = 2,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input logic           clk_I,
  input logic           rst,
  stage_id_fwd_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ICS   = 7'b0010011;
  localparam logic [6:0] OP_IL    = 7'b0000011;
  localparam logic [6:0] OP_IJ    = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;

  logic [31:0] w_inst;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2;
  assign w_inst = bus.in_inst;
  assign w_opc  = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_f7   = w_inst[31:25];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];
  assign bus.RF_raddr1 = w_rs1;
  assign bus.RF_raddr2 = w_rs2;

  logic w_r, w_ics, w_il, w_ij, w_s, w_auipc, w_u, w_b, w_j, w_i;
  assign w_r     = (w_opc == OP_R);
  assign w_ics   = (w_opc == OP_ICS);
  assign w_il    = (w_opc == OP_IL);
  assign w_ij    = (w_opc == OP_IJ);
  assign w_s     = (w_opc == OP_S);
  assign w_auipc = (w_opc == OP_AUIPC);
  assign w_u     = (w_opc == OP_LUI) | w_auipc;
  assign w_b     = (w_opc == OP_B);
  assign w_j     = (w_opc == OP_J);
  assign w_i     = w_ics | w_il | w_ij;

  logic w_r_ok, w_m;
  // R-type funct7 legality; funct7=1 selects the multiply/divide unit
  always_comb begin
    w_r_ok = 1'b0;
    w_m    = 1'b0;
    if (w_f7 == 7'b0000000) begin
      w_r_ok = 1'b1;
    end else if (w_f7 == 7'b0100000) begin
      w_r_ok = (w_f3 == 3'b000) | (w_f3 == 3'b101);
    end else if (w_f7 == 7'b0000001) begin
`ifdef ID_MULDIV_EN
      w_r_ok = 1'b1;
      w_m    = w_r;
`else
      w_r_ok = (w_f3 == 3'b000);
      w_m    = w_r & (w_f3 == 3'b000);
`endif
    end
  end

  logic w_illegal;
  assign w_illegal = ~(w_r | w_i | w_s | w_u | w_b | w_j) | (w_r & ~w_r_ok);

  // Shifts: SFTop = {right, arithmetic}
  logic       w_sft;
  logic [1:0] w_sftop;
  assign w_sft   = ((w_r & ~w_m) | w_ics) & ((w_f3 == 3'b001) | (w_f3 == 3'b101));
  assign w_sftop = {w_f3[2], w_f7[5]};

  // ALUop: 0 add, 1 sub/compare, 2 slt, 3 sltu, 4 xor, 5 or, 6 and; M-ops pass funct3
  logic [2:0] w_aluop;
  always_comb begin
    w_aluop = 3'd0;
    if (w_m) begin
      w_aluop = w_f3;
    end else if (w_b) begin
      w_aluop = 3'd1;
    end else if ((w_r | w_ics) & ~w_sft) begin
      case (w_f3)
        3'b000:  w_aluop = (w_r & w_f7[5]) ? 3'd1 : 3'd0;
        3'b010:  w_aluop = 3'd2;
        3'b011:  w_aluop = 3'd3;
        3'b100:  w_aluop = 3'd4;
        3'b110:  w_aluop = 3'd5;
        3'b111:  w_aluop = 3'd6;
        default: w_aluop = 3'd0;
      endcase
    end
  end

  logic [19:0] w_dcr;
  assign w_dcr = w_illegal ? 20'd0 :
                 {w_auipc, w_f3, w_r, w_ics, w_il, w_ij, w_s, w_u, w_b, w_j, w_m,
                  w_i, w_sft, w_aluop, w_sftop};

  // Immediate extraction by format
  logic [31:0] w_imm;
  always_comb begin
    w_imm = 32'd0;
    if (w_i)      w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
    else if (w_s) w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    else if (w_b) w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    else if (w_u) w_imm = {w_inst[31:12], 12'd0};
    else if (w_j) w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  end

  logic [4:0] w_rd;
  assign w_rd = ((w_r | w_i | w_u | w_j) & ~w_illegal) ? w_inst[11:7] : 5'd0;

  // Bypass chain: each stage overrides anything older, so index 0 (youngest) wins
  for (genvar g = 0; g < N_FWD; g++) begin : g_byp
    logic        w_m1, w_m2, w_p1, w_p2;
    logic [31:0] w_v1, w_v2;
    assign w_m1 = bus.fwd_valid[g] & (bus.fwd_rd[5*g +: 5] == w_rs1) & (w_rs1 != 5'd0);
    assign w_m2 = bus.fwd_valid[g] & (bus.fwd_rd[5*g +: 5] == w_rs2) & (w_rs2 != 5'd0);
    if (g == N_FWD - 1) begin : g_last
      assign w_v1 = w_m1 ? bus.fwd_data[32*g +: 32] : bus.RF_rdata1;
      assign w_v2 = w_m2 ? bus.fwd_data[32*g +: 32] : bus.RF_rdata2;
      assign w_p1 = w_m1 & bus.fwd_pend[g];
      assign w_p2 = w_m2 & bus.fwd_pend[g];
    end else begin : g_mid
      assign w_v1 = w_m1 ? bus.fwd_data[32*g +: 32] : g_byp[g+1].w_v1;
      assign w_v2 = w_m2 ? bus.fwd_data[32*g +: 32] : g_byp[g+1].w_v2;
      assign w_p1 = w_m1 ? bus.fwd_pend[g] : g_byp[g+1].w_p1;
      assign w_p2 = w_m2 ? bus.fwd_pend[g] : g_byp[g+1].w_p2;
    end
  end

  // Sources the instruction does not read never stall and never take bypass data
  logic        w_use1, w_use2, w_stall;
  logic [31:0] w_rr1, w_rr2;
  assign w_use1  = w_r | w_i | w_s | w_b;
  assign w_use2  = w_r | w_s | w_b;
  assign w_rr1   = w_use1 ? g_byp[0].w_v1 : bus.RF_rdata1;
  assign w_rr2   = w_use2 ? g_byp[0].w_v2 : bus.RF_rdata2;
  assign w_stall = bus.in_valid & ((w_use1 & g_byp[0].w_p1) | (w_use2 & g_byp[0].w_p2));

  logic [31:0] w_sum_pc, w_sum_rs, w_tgt;
  assign w_sum_pc = bus.in_pc + w_imm;
  assign w_sum_rs = w_rr1 + w_imm;
  assign w_tgt = (w_b | w_j) ? {w_sum_pc[31:2], 2'b00} :
                 w_ij        ? {w_sum_rs[31:2], 2'b00} : bus.in_pc + 32'd4;

  logic        r_valid, r_illegal;
  logic [31:0] r_pc, r_rr1, r_rr2, r_imm, r_tgt;
  logic [4:0]  r_rd;
  logic [19:0] r_dcr;
  logic        w_adv, w_accept;
  assign w_adv        = ~r_valid | bus.out_ready;
  assign bus.in_ready = w_adv & ~w_stall & ~bus.flush;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Payload register: reset, then flush, then accept, then bubble, else hold
  always_ff @(posedge clk_I) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= RST_PC;
      r_tgt     <= RST_PC;
      r_rr1     <= 32'd0;
      r_rr2     <= 32'd0;
      r_imm     <= 32'd0;
      r_rd      <= 5'd0;
      r_dcr     <= 20'd0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= bus.in_pc;
      r_tgt     <= w_tgt;
      r_rr1     <= w_rr1;
      r_rr2     <= w_rr2;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_dcr     <= w_dcr;
      r_illegal <= w_illegal;
    end else if (w_adv) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_rr1     = r_rr1;
  assign bus.out_rr2     = r_rr2;
  assign bus.out_imm     = r_imm;
  assign bus.out_tgt     = r_tgt;
  assign bus.out_rd      = r_rd;
  assign bus.out_dcr     = r_dcr;
  assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_stage_id_fwd.sv
// Bench for stage_id_fwd: directed pipeline scenarios, then randomized traffic against a reference model.
// Instructions are built from descriptors (kind, rd, rs, imm) so expectations never come from decoding.
// Inputs change 1 unit after a rising edge; outputs are sampled 1 unit after the next rising edge.
module tb_stage_id_fwd;
  localparam int N = 2;
  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam int K_ADDI = 0, K_LW = 1, K_R = 2, K_MD = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_JAL = 6, K_LUI = 7, K_JALR = 8, K_BAD = 9;
`ifdef ID_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk_I = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  always #5 clk_I = ~clk_I;

  stage_id_fwd_if #(.N_FWD(N)) bus ();
  stage_id_fwd #(.N_FWD(N), .RST_PC(RPC)) dut (.clk_I(clk_I), .rst(rst), .bus(bus));

  // descriptor of the instruction on in_inst
  int          d_kind;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic [2:0]  d_f3;
  // bypass sources (index 0 = youngest)
  logic        fv [N];
  logic [4:0]  frd [N];
  logic [31:0] fd [N];
  logic        fp [N];
  // expected EX-side registers
  logic        m_valid, m_ill, m_mb;
  logic [31:0] m_pc, m_rr1, m_rr2, m_imm, m_tgt;
  logic [4:0]  m_rd;
  logic [2:0]  addi_f3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit use1(input int k);
    return k inside {K_ADDI, K_LW, K_R, K_MD, K_SW, K_BEQ, K_JALR};
  endfunction
  function automatic bit use2(input int k);
    return k inside {K_R, K_MD, K_SW, K_BEQ};
  endfunction
  function automatic bit is_ill(input int k, input logic [2:0] f3);
    return (k == K_BAD) || (k == K_MD && !MULDIV && f3 != 3'b000);
  endfunction
  function automatic bit writes(input int k, input logic [2:0] f3);
    return (k inside {K_ADDI, K_LW, K_R, K_MD, K_JAL, K_LUI, K_JALR}) && !is_ill(k, f3);
  endfunction

  // youngest matching source wins; x0 never matches
  task automatic byp(input logic [4:0] rs, input logic [31:0] rf, output logic pend, output logic [31:0] val);
    pend = 1'b0;
    val  = rf;
    if (rs != 5'd0 && fv[0] && frd[0] == rs) begin
      pend = fp[0];
      val  = fd[0];
    end else if (rs != 5'd0 && fv[1] && frd[1] == rs) begin
      pend = fp[1];
      val  = fd[1];
    end
  endtask

  task automatic set_inst(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic [2:0] f3);
    logic [31:0] iv;
    d_kind = kind; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2; d_f3 = f3;
    case (kind)
      K_ADDI: begin iv = {imm[11:0], rs1, f3, rd, 7'b0010011}; d_imm = {{20{imm[11]}}, imm[11:0]}; end
      K_LW:   begin iv = {imm[11:0], rs1, 3'b010, rd, 7'b0000011}; d_imm = {{20{imm[11]}}, imm[11:0]}; end
      K_R:    begin iv = {7'b0000000, rs2, rs1, f3, rd, 7'b0110011}; d_imm = 32'd0; end
      K_MD:   begin iv = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011}; d_imm = 32'd0; end
      K_SW:   begin iv = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}; d_imm = {{20{imm[11]}}, imm[11:0]}; end
      K_BEQ:  begin iv = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
                    d_imm = {{19{imm[12]}}, imm[12:1], 1'b0}; end
      K_JAL:  begin iv = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                    d_imm = {{11{imm[20]}}, imm[20:1], 1'b0}; end
      K_LUI:  begin iv = {imm[31:12], rd, 7'b0110111}; d_imm = {imm[31:12], 12'h000}; end
      K_JALR: begin iv = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; d_imm = {{20{imm[11]}}, imm[11:0]}; end
      default: begin iv = {imm[24:0], 7'b1111111}; d_imm = 32'd0; end
    endcase
    bus.in_inst = iv;
  endtask

  task automatic no_fwd();
    fv[0] = 1'b0; fv[1] = 1'b0; fp[0] = 1'b0; fp[1] = 1'b0;
    frd[0] = 5'd0; frd[1] = 5'd0; fd[0] = 32'd0; fd[1] = 32'd0;
  endtask

  // one clock: check handshake, advance model, check registered outputs
  task automatic cycle(input string tag);
    logic p1, p2, stall, rdy, acc;
    logic [31:0] v1, v2, e1, e2, tgt;
    bus.fwd_valid = {fv[1], fv[0]};
    bus.fwd_rd    = {frd[1], frd[0]};
    bus.fwd_data  = {fd[1], fd[0]};
    bus.fwd_pend  = {fp[1], fp[0]};
    #1;
    byp(d_rs1, bus.RF_rdata1, p1, v1);
    byp(d_rs2, bus.RF_rdata2, p2, v2);
    stall = bus.in_valid && ((use1(d_kind) && p1) || (use2(d_kind) && p2));
    rdy   = (!m_valid || bus.out_ready) && !stall && !bus.flush;
    acc   = bus.in_valid && rdy;
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
    if (use1(d_kind)) chk({tag, ".raddr1"}, {27'd0, bus.RF_raddr1}, {27'd0, d_rs1});
    e1 = use1(d_kind) ? v1 : bus.RF_rdata1;
    e2 = use2(d_kind) ? v2 : bus.RF_rdata2;
    if (d_kind == K_BEQ || d_kind == K_JAL) tgt = (bus.in_pc + d_imm) & ~32'd3;
    else if (d_kind == K_JALR)              tgt = (e1 + d_imm) & ~32'd3;
    else                                     tgt = bus.in_pc + 32'd4;
    @(posedge clk_I);
    if (bus.flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_pc = bus.in_pc; m_rr1 = e1; m_rr2 = e2; m_imm = d_imm; m_tgt = tgt;
      m_rd  = writes(d_kind, d_f3) ? d_rd : 5'd0;
      m_ill = is_ill(d_kind, d_f3);
      m_mb  = (d_kind == K_MD) && !m_ill;
    end else if (!m_valid || bus.out_ready) m_valid = 1'b0;
    #1;
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk({tag, ".pc"}, bus.out_pc, m_pc);
    chk({tag, ".rr1"}, bus.out_rr1, m_rr1);
    chk({tag, ".rr2"}, bus.out_rr2, m_rr2);
    chk({tag, ".imm"}, bus.out_imm, m_imm);
    chk({tag, ".tgt"}, bus.out_tgt, m_tgt);
    chk({tag, ".rd"}, {27'd0, bus.out_rd}, {27'd0, m_rd});
    chk({tag, ".illegal"}, {31'd0, bus.out_illegal}, {31'd0, m_ill});
    chk({tag, ".dcr_m"}, {31'd0, bus.out_dcr[7]}, {31'd0, m_mb});
  endtask

  initial begin
    // reset has priority over a pending accept
    rst = 1'b1; bus.in_valid = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.in_pc = 32'h0000_0500; bus.RF_rdata1 = 32'd0; bus.RF_rdata2 = 32'd0;
    set_inst(K_ADDI, 5'd3, 5'd0, 5'd0, 32'd1, 3'd0);
    no_fwd();
    bus.fwd_valid = '0; bus.fwd_rd = '0; bus.fwd_data = '0; bus.fwd_pend = '0;
    repeat (2) @(posedge clk_I);
    #1;
    rst = 1'b0;
    m_valid = 1'b0; m_pc = RPC; m_tgt = RPC; m_rr1 = 32'd0; m_rr2 = 32'd0;
    m_imm = 32'd0; m_rd = 5'd0; m_ill = 1'b0; m_mb = 1'b0;
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.rd", {27'd0, bus.out_rd}, 32'd0);
    chk("rst.pc", bus.out_pc, RPC);
    chk("rst.tgt", bus.out_tgt, RPC);
    chk("rst.dcr", {12'd0, bus.out_dcr}, 32'd0);
    chk("rst.imm", bus.out_imm, 32'd0);
    chk("rst.illegal", {31'd0, bus.out_illegal}, 32'd0);

    // addi x5,x0,7 @0x100
    bus.in_valid = 1'b0;
    cycle("idle");
    set_inst(K_ADDI, 5'd5, 5'd0, 5'd0, 32'd7, 3'd0);
    bus.in_valid = 1'b1; bus.in_pc = 32'h100;
    chk("t1.enc", bus.in_inst, 32'h0070_0293);
    cycle("t1");
    chk("t1.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1.rd", {27'd0, bus.out_rd}, 32'd5);
    chk("t1.imm", bus.out_imm, 32'd7);
    chk("t1.tgt", bus.out_tgt, 32'h104);

    // add x6,x5,x5 with both stages holding x5: youngest wins
    set_inst(K_R, 5'd6, 5'd5, 5'd5, 32'd0, 3'd0);
    bus.in_pc = 32'h104;
    fv[0] = 1'b1; fv[1] = 1'b1; frd[0] = 5'd5; frd[1] = 5'd5; fd[0] = 32'h1234; fd[1] = 32'hAAAA;
    cycle("t2");
    chk("t2.rr1", bus.out_rr1, 32'h1234);
    chk("t2.rr2", bus.out_rr2, 32'h1234);

    // load-use: youngest is pending -> bubble, then resolves to 0x55
    fp[0] = 1'b1;
    cycle("t3");
    chk("t3.bubble", {31'd0, bus.out_valid}, 32'd0);
    fp[0] = 1'b0; fd[0] = 32'h55;
    cycle("t3b");
    chk("t3b.rr1", bus.out_rr1, 32'h55);
    chk("t3b.valid", {31'd0, bus.out_valid}, 32'd1);

    // backpressure: payload frozen for 3 cycles, then next inst accepted at once
    no_fwd();
    bus.out_ready = 1'b0;
    set_inst(K_ADDI, 5'd7, 5'd1, 5'd0, 32'h10, 3'd0);
    bus.in_pc = 32'h108; bus.RF_rdata1 = 32'h9;
    for (int c = 0; c < 3; c++) begin
      cycle("t4");
      chk("t4.hold_rr1", bus.out_rr1, 32'h55);
      chk("t4.hold_pc", bus.out_pc, 32'h104);
    end
    bus.out_ready = 1'b1;
    cycle("t4r");
    chk("t4r.pc", bus.out_pc, 32'h108);

    // flush drops the offered instruction
    bus.flush = 1'b1;
    set_inst(K_LUI, 5'd9, 5'd0, 5'd0, 32'hABCDE000, 3'd0);
    bus.in_pc = 32'h10C;
    cycle("t5");
    chk("t5.valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("t5b");
    chk("t5b.pc", bus.out_pc, 32'h108);

    // targets and M-extension legality
    bus.in_valid = 1'b1;
    set_inst(K_JAL, 5'd1, 5'd0, 5'd0, 32'h800, 3'd0);
    bus.in_pc = 32'hFFFF_F900;
    cycle("t6j");
    chk("t6j.tgt", bus.out_tgt, 32'h100);
    fv[0] = 1'b1; frd[0] = 5'd7; fd[0] = 32'h2001;
    set_inst(K_JALR, 5'd0, 5'd7, 5'd0, 32'd3, 3'd0);
    bus.in_pc = 32'h200;
    cycle("t6r");
    chk("t6r.tgt", bus.out_tgt, 32'h2004);
    no_fwd();
    set_inst(K_MD, 5'd1, 5'd2, 5'd3, 32'd0, 3'b100);
    cycle("t6d");
    chk("t6d.illegal", {31'd0, bus.out_illegal}, {31'd0, !MULDIV});
    chk("t6d.rd", {27'd0, bus.out_rd}, MULDIV ? 32'd1 : 32'd0);
    set_inst(K_MD, 5'd1, 5'd2, 5'd3, 32'd0, 3'b000);
    cycle("t6m");
    chk("t6m.dcr_m", {31'd0, bus.out_dcr[7]}, 32'd1);

    // x0 never matches a pending source; unused rs2 field never stalls
    fv[0] = 1'b1; frd[0] = 5'd0; fp[0] = 1'b1; bus.RF_rdata1 = 32'h77;
    set_inst(K_R, 5'd6, 5'd0, 5'd0, 32'd0, 3'd0);
    cycle("t7");
    chk("t7.rr1", bus.out_rr1, 32'h77);
    frd[0] = 5'd3;
    set_inst(K_ADDI, 5'd6, 5'd1, 5'd0, 32'd3, 3'd0);
    cycle("t8");
    chk("t8.valid", {31'd0, bus.out_valid}, 32'd1);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      int kind;
      logic [2:0] f3;
      kind = int'($urandom_range(0, 9));
      f3 = (kind == K_ADDI) ? addi_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      set_inst(kind, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, f3);
      bus.in_pc = $urandom; bus.RF_rdata1 = $urandom; bus.RF_rdata2 = $urandom;
      fv[0] = 1'($urandom_range(0, 1)); fv[1] = 1'($urandom_range(0, 1));
      frd[0] = 5'($urandom_range(0, 7)); frd[1] = 5'($urandom_range(0, 7));
      fd[0] = $urandom; fd[1] = $urandom;
      fp[0] = ($urandom_range(0, 3) == 0); fp[1] = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
